// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a request/response handshake.
// Inserts WAIT_CYCLES wait states before each valid access. Misaligned or
// out-of-range requests are answered at once with respErr and never touch memory.
//
// Ports:
//   clk, rst                   single clock, synchronous active-high reset
//   reqValid/reqReady          request handshake (reqReady high only when idle)
//   reqWrite, reqAddr          request kind (1 = store) and byte address
//   reqWData, reqByteEn        store data and byte-lane enables
//   respValid/respReady        response handshake, held until consumed
//   respRData, respErr         load data (0 for stores/errors) and error flag
//
// DEPTH must be at least 2.
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  input  logic [3:0]  reqByteEn,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respRData,
  output logic        respErr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [3:0]     cnt;

  // Request fields captured on acceptance, used when the access is deferred.
  logic           cap_write;
  logic [AW-1:0]  cap_idx;
  logic [31:0]    cap_wdata;
  logic [3:0]     cap_be;

  // No reset: contents survive reset and are undefined after power-up.
  logic [31:0]    mem [DEPTH];

  logic           req_err;
  logic           acc_now;
  logic           acc_write;
  logic [AW-1:0]  acc_idx;
  logic [31:0]    acc_wdata;
  logic [3:0]     acc_be;

  assign reqReady = (state == IDLE);

  assign req_err = (reqAddr[1:0] != 2'b00) ||
                   ({2'b00, reqAddr[31:2]} >= 32'(DEPTH));

  // With no wait states the access happens on the accepting edge, so it must
  // use the live request inputs; otherwise it uses the captured copy.
  assign acc_write = (state == IDLE) ? reqWrite            : cap_write;
  assign acc_idx   = (state == IDLE) ? reqAddr[AW+1:2]     : cap_idx;
  assign acc_wdata = (state == IDLE) ? reqWData            : cap_wdata;
  assign acc_be    = (state == IDLE) ? reqByteEn           : cap_be;

  // Asserted exactly on the edge that enters RESP for a valid request.
  // Gated by rst so an aborted store is never committed.
  assign acc_now = !rst &&
                   (((state == IDLE) && reqValid && !req_err && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt == 4'd0)));

  always_ff @(posedge clk) begin
    if (acc_now && acc_write) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      respValid <= 1'b0;
      respErr   <= 1'b0;
      respRData <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            cap_write <= reqWrite;
            cap_idx   <= reqAddr[AW+1:2];
            cap_wdata <= reqWData;
            cap_be    <= reqByteEn;
            if (req_err) begin
              state     <= RESP;
              respValid <= 1'b1;
              respErr   <= 1'b1;
              respRData <= 32'd0;
            end else if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              respValid <= 1'b1;
              respErr   <= 1'b0;
              respRData <= acc_write ? 32'd0 : mem[acc_idx];
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          // Leave on the cycle after the counter has reached zero.
          if (cnt == 4'd0) begin
            state     <= RESP;
            respValid <= 1'b1;
            respErr   <= 1'b0;
            respRData <= acc_write ? 32'd0 : mem[acc_idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (respReady) begin
            state     <= IDLE;
            respValid <= 1'b0;
            respErr   <= 1'b0;
            respRData <= 32'd0;
          end
        end
        default: begin
          state     <= IDLE;
          respValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance A uses WAIT_CYCLES=2, instance B
// uses WAIT_CYCLES=0 with respReady tied high. Both use DEPTH=64 (byte 0x100
// is the first out-of-range address).
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A
  logic        a_req_valid, a_req_ready, a_req_write;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_be;
  logic        a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_resp_rdata;

  // Instance B
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .reqValid(a_req_valid), .reqReady(a_req_ready), .reqWrite(a_req_write),
    .reqAddr(a_req_addr), .reqWData(a_req_wdata), .reqByteEn(a_req_be),
    .respValid(a_resp_valid), .respReady(a_resp_ready),
    .respRData(a_resp_rdata), .respErr(a_resp_err)
  );

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .reqValid(b_req_valid), .reqReady(b_req_ready), .reqWrite(b_req_write),
    .reqAddr(b_req_addr), .reqWData(b_req_wdata), .reqByteEn(b_req_be),
    .respValid(b_resp_valid), .respReady(b_resp_ready),
    .respRData(b_resp_rdata), .respErr(b_resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on instance A; lat is the cycle offset from acceptance cycle T
  // at which respValid is first seen (99 if never seen).
  task automatic req_a(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output int lat,
                       output logic [31:0] rd, output logic er);
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr;
    a_req_wdata = wd;   a_req_be = be;    a_resp_ready = 1'b0;
    @(negedge clk);
    check("a_rdy_before_accept", {31'd0, a_req_ready}, 32'd1);
    @(posedge clk); #1;
    // Scramble request inputs: they must be don't-care after acceptance.
    a_req_valid = 1'b0; a_req_write = ~wr; a_req_addr = $urandom;
    a_req_wdata = $urandom; a_req_be = 4'hF;
    lat = 1;
    @(negedge clk);
    while (!a_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!a_resp_valid) lat = 99;
    rd = a_resp_rdata;
    er = a_resp_err;
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
  endtask

  // Instance B stimulus table.
  logic        b_wr  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] b_ad  [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h6, 32'h100};
  logic [31:0] b_wd  [6] = '{32'hA5A5A5A5, 32'h01020304, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] b_exd [6] = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'h01020304, 32'h0, 32'h0};
  logic        b_exe [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        saw;

    rst = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'd0;
    a_req_wdata = 32'd0; a_req_be = 4'd0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'd0;
    b_req_wdata = 32'd0; b_req_be = 4'd0; b_resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, a_resp_err}, 32'd0);
    check("rst_resp_rdata", a_resp_rdata, 32'd0);
    rst = 1'b0;

    // Store then load
    req_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    check("st_lat", lat, 3);
    check("st_rdata", rd, 32'd0);
    check("st_err", {31'd0, er}, 32'd0);
    req_a(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("ld_lat", lat, 3);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err", {31'd0, er}, 32'd0);

    // Partial stores
    req_a(1'b1, 32'h10, 32'h00000011, 4'b0001, lat, rd, er);
    req_a(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("part_0001", rd, 32'hDEADBE11);
    req_a(1'b1, 32'h10, 32'hAABBCCDD, 4'b1010, lat, rd, er);
    req_a(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("part_1010", rd, 32'hAAADCC11);
    req_a(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
    req_a(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("part_0000_noop", rd, 32'hAAADCC11);

    // Last valid word
    req_a(1'b1, 32'hFC, 32'h600DF00D, 4'hF, lat, rd, er);
    req_a(1'b0, 32'hFC, 32'h0, 4'h0, lat, rd, er);
    check("last_word", rd, 32'h600DF00D);
    check("last_word_err", {31'd0, er}, 32'd0);

    // Error requests
    req_a(1'b1, 32'h0, 32'h11112222, 4'hF, lat, rd, er);
    req_a(1'b0, 32'h12, 32'h0, 4'h0, lat, rd, er);
    check("mis_lat", lat, 1);
    check("mis_err", {31'd0, er}, 32'd1);
    check("mis_rdata", rd, 32'd0);
    req_a(1'b0, 32'h100, 32'h0, 4'h0, lat, rd, er);
    check("oor_lat", lat, 1);
    check("oor_err", {31'd0, er}, 32'd1);
    check("oor_rdata", rd, 32'd0);
    req_a(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    check("mis_st_err", {31'd0, er}, 32'd1);
    req_a(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    check("oor_st_err", {31'd0, er}, 32'd1);
    req_a(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("mis_st_no_write", rd, 32'hAAADCC11);
    req_a(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    check("oor_st_no_write", rd, 32'h11112222);

    // Backpressure: hold respReady low for 5 cycles while a new request is offered
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h10; a_resp_ready = 1'b0;
    @(posedge clk); #1;
    a_req_addr = 32'h0;  // still valid: must be ignored outside IDLE
    lat = 1;
    @(negedge clk);
    while (!a_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("bp_valid_%0d", i), {31'd0, a_resp_valid}, 32'd1);
      check($sformatf("bp_rdata_%0d", i), a_resp_rdata, 32'hAAADCC11);
      check($sformatf("bp_ready_%0d", i), {31'd0, a_req_ready}, 32'd0);
    end
    a_req_valid = 1'b0;
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_ready", {31'd0, a_req_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, a_resp_valid}, 32'd0);

    // Reset during WAIT aborts a pending store
    req_a(1'b1, 32'h20, 32'h12345678, 4'hF, lat, rd, er);
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20;
    a_req_wdata = 32'hCAFEF00D; a_req_be = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_resp_valid) saw = 1'b1;
    end
    check("rstw_no_resp", {31'd0, saw}, 32'd0);
    check("rstw_ready", {31'd0, a_req_ready}, 32'd1);
    req_a(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    check("rstw_no_commit", rd, 32'h12345678);

    // Instance B: back-to-back with no wait states, respReady tied high
    @(posedge clk); #1;
    b_req_valid = 1'b1;
    b_req_write = b_wr[0]; b_req_addr = b_ad[0]; b_req_wdata = b_wd[0]; b_req_be = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("b_ready_%0d", i), {31'd0, b_req_ready}, 32'd1);
      check($sformatf("b_novalid_%0d", i), {31'd0, b_resp_valid}, 32'd0);
      @(negedge clk);
      check($sformatf("b_valid_%0d", i), {31'd0, b_resp_valid}, 32'd1);
      check($sformatf("b_rdata_%0d", i), b_resp_rdata, b_exd[i]);
      check($sformatf("b_err_%0d", i), {31'd0, b_resp_err}, {31'd0, b_exe[i]});
      check($sformatf("b_busy_%0d", i), {31'd0, b_req_ready}, 32'd0);
      @(posedge clk); #1;
      if (i < 5) begin
        b_req_write = b_wr[i+1]; b_req_addr = b_ad[i+1]; b_req_wdata = b_wd[i+1];
      end else begin
        b_req_valid = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
